bcd_counter_chain: RTL and testbench

//   Parametrised multi-digit BCD up/down counter with built-in prescaler.

---
 rtl/seven_seg_pkg.sv | 12 +
 rtl/bcd_digit.sv | 45 ++++
 rtl/bcd_counter_chain.sv | 74 +++++++
 tb/tb_bcd_counter_chain.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared BCD definitions for the counter chain and the seven-segment decoder.
package seven_seg_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  // Clamp an arbitrary nibble into the legal BCD range.
  function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the chain: holds its nibble, steps up/down on inc, and
// produces a combinational carry/borrow into the next digit.
module bcd_digit
  import seven_seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [BCD_W-1:0] load_nib,
  input  logic             inc,
  input  logic             up,
  output logic [BCD_W-1:0] q,
  output logic             co
);

  logic [BCD_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      q_d = bcd_sat(load_nib);
    end else if (inc) begin
      if (up) begin
        q_d = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
      end else begin
        q_d = (q_q == '0) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign co = inc & (up ? (q_q == BCD_MAX) : (q_q == '0));

endmodule

// File: rtl/bcd_counter_chain.sv
// Multi-digit BCD up/down counter with prescaler, clear, load and
// step/wrap status pulses.
module bcd_counter_chain
  import seven_seg_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    clear,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    step,
  output logic                    wrap
);

  localparam int unsigned PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PreMax = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          step_q, step_d;
  logic          wrap_q, wrap_d;
  logic          adv;
  logic [DIGITS:0] carry;

  assign adv      = en & (pre_q == PreMax);
  assign carry[0] = adv;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .load     (load),
      .load_nib (load_val[g*BCD_W +: BCD_W]),
      .inc      (carry[g]),
      .up       (up),
      .q        (bcd[g*BCD_W +: BCD_W]),
      .co       (carry[g+1])
    );
  end

  always_comb begin
    pre_d = pre_q;
    if (clear || load) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = adv ? '0 : pre_q + 1'b1;
    end
    // Clear and load swallow a coincident advance.
    step_d = adv & ~clear & ~load;
    wrap_d = step_d & carry[DIGITS];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q  <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Directed self-checking bench: a 2-digit/prescale-4 instance and a
// 3-digit/prescale-1 instance.
module tb_bcd_counter_chain;

  logic        clk;
  logic        rst;
  logic        en, up, clear, load;
  logic [7:0]  load_val;
  logic [7:0]  bcd;
  logic        step, wrap;

  logic        en_b, clear_b;
  logic [11:0] bcd_b;
  logic        step_b, wrap_b;

  int checks = 0;
  int errors = 0;
  int wrap_cnt;

  bcd_counter_chain #(.DIGITS(2), .PRESCALE(4)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .bcd      (bcd),
    .step     (step),
    .wrap     (wrap)
  );

  bcd_counter_chain #(.DIGITS(3), .PRESCALE(1)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .en       (en_b),
    .up       (1'b1),
    .clear    (clear_b),
    .load     (1'b0),
    .load_val (12'h000),
    .bcd      (bcd_b),
    .step     (step_b),
    .wrap     (wrap_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    run(1);
    load     = 1'b0;
  endtask

  function automatic logic [11:0] to_bcd3(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  initial begin
    rst = 1'b0; en = 1'b1; up = 1'b1; clear = 1'b0; load = 1'b1; load_val = 8'h55;
    en_b = 1'b0; clear_b = 1'b0;

    // Reset dominates load
    for (int i = 0; i < 3; i++) begin
      run(1);
      check_eq("rst_bcd", 32'(bcd), 32'h00);
      check_eq("rst_step", 32'(step), 0);
      check_eq("rst_wrap", 32'(wrap), 0);
    end
    check_eq("rst_bcd_b", 32'(bcd_b), 32'h000);
    rst = 1'b1; load = 1'b0;
    run(3);
    check_eq("pre_hold_bcd", 32'(bcd), 32'h00);
    check_eq("pre_hold_step", 32'(step), 0);
    run(1);
    check_eq("first_step_bcd", 32'(bcd), 32'h01);
    check_eq("first_step", 32'(step), 1);
    run(1);
    check_eq("step_pulse_end", 32'(step), 0);

    // Increment and digit carry
    do_load(8'h08);
    check_eq("load08", 32'(bcd), 32'h08);
    check_eq("load_step0", 32'(step), 0);
    run(3);
    check_eq("inc_wait", 32'(bcd), 32'h08);
    run(1);
    check_eq("inc09", 32'(bcd), 32'h09);
    check_eq("inc09_step", 32'(step), 1);
    run(3);
    check_eq("inc09_hold", 32'(bcd), 32'h09);
    run(1);
    check_eq("carry10", 32'(bcd), 32'h10);

    // Chain wrap up then down
    do_load(8'h99);
    run(4);
    check_eq("wrap_up_bcd", 32'(bcd), 32'h00);
    check_eq("wrap_up_step", 32'(step), 1);
    check_eq("wrap_up_wrap", 32'(wrap), 1);
    run(1);
    check_eq("wrap_up_1clk", 32'(wrap), 0);
    up = 1'b0;
    run(2);
    check_eq("down_wait", 32'(bcd), 32'h00);
    run(1);
    check_eq("wrap_dn_bcd", 32'(bcd), 32'h99);
    check_eq("wrap_dn_wrap", 32'(wrap), 1);

    // Borrow across digits
    do_load(8'h10);
    run(4);
    check_eq("borrow09", 32'(bcd), 32'h09);
    check_eq("borrow_wrap0", 32'(wrap), 0);
    up = 1'b1;

    // Saturating load, and load on the advance edge
    do_load(8'hA5);
    check_eq("sat_load", 32'(bcd), 32'h95);
    run(3);
    do_load(8'h42);
    check_eq("load_on_adv", 32'(bcd), 32'h42);
    check_eq("load_on_adv_step", 32'(step), 0);
    run(3);
    check_eq("post_load_wait", 32'(bcd), 32'h42);
    run(1);
    check_eq("post_load_step", 32'(bcd), 32'h43);
    check_eq("post_load_step_p", 32'(step), 1);

    // Enable drop mid-prescale
    do_load(8'h20);
    run(2);
    en = 1'b0;
    run(10);
    check_eq("en_hold_bcd", 32'(bcd), 32'h20);
    check_eq("en_hold_step", 32'(step), 0);
    en = 1'b1;
    run(1);
    check_eq("reen_wait", 32'(bcd), 32'h20);
    run(1);
    check_eq("reen_step_bcd", 32'(bcd), 32'h21);
    check_eq("reen_step", 32'(step), 1);

    // Clear beats load
    clear = 1'b1; load = 1'b1; load_val = 8'h77;
    run(1);
    clear = 1'b0; load = 1'b0;
    check_eq("clear_bcd", 32'(bcd), 32'h00);
    check_eq("clear_step", 32'(step), 0);

    // Prescale-1, three digits: full wrap over 1000 clocks
    en_b = 1'b1;
    wrap_cnt = 0;
    for (int i = 1; i <= 1000; i++) begin
      run(1);
      if (wrap_b) wrap_cnt++;
      if (i == 500) check_eq("b_500", 32'(bcd_b), 32'(to_bcd3(500)));
      if (i == 999) begin
        check_eq("b_999", 32'(bcd_b), 32'h999);
        check_eq("b_999_wrap", 32'(wrap_b), 0);
      end
    end
    check_eq("b_1000_bcd", 32'(bcd_b), 32'h000);
    check_eq("b_1000_wrap", 32'(wrap_b), 1);
    check_eq("b_wrap_once", 32'(wrap_cnt), 1);
    run(499);
    check_eq("b_pre_clear", 32'(bcd_b), 32'(to_bcd3(499)));
    clear_b = 1'b1;
    run(1);
    clear_b = 1'b0;
    check_eq("b_clear", 32'(bcd_b), 32'h000);
    check_eq("b_clear_step", 32'(step_b), 0);
    run(1);
    check_eq("b_restart", 32'(bcd_b), 32'h001);
    check_eq("b_restart_step", 32'(step_b), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
